// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage feeding the control unit. Reads 16-bit words
//   from word-addressed program memory over a req/ready port that may insert
//   wait states. Words are prefetched into a 2-entry queue and handed over as
//   {instr_out, instr_pc} on a valid/ready handshake. A redirect pulse flushes
//   the queue and restarts fetching at redirect_pc.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   mem_req      memory read request (registered)
//   mem_addr     word address of the outstanding request
//   mem_ready    memory completes the request this cycle
//   mem_data     read data, used only when mem_req && mem_ready
//   instr_valid  queue head valid (registered)
//   instr_out    queue head instruction
//   instr_pc     address the queue head was fetched from
//   instr_ready  control unit consumes the head this cycle
//   redirect_en  one-cycle flush/restart pulse
//   redirect_pc  restart address
//   fetch_pc     next address to be requested (trace)
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0100,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  output logic        instr_valid,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic [15:0] fetch_pc
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  // The queue holds at most two entries; the FSM logic below relies on it.
  localparam logic [1:0] FULL = 2'(QUEUE_DEPTH);

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] e0_instr_q, e0_instr_d, e0_pc_q, e0_pc_d;
  logic [15:0] e1_instr_q, e1_instr_d, e1_pc_q, e1_pc_d;

  logic        push;
  logic        pop;
  logic [1:0]  count_after_pop;

  assign mem_req     = (state_q != ST_IDLE);
  assign mem_addr    = addr_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr_out   = e0_instr_q;
  assign instr_pc    = e0_pc_q;
  assign fetch_pc    = pc_q;

  assign pop             = instr_valid && instr_ready;
  assign count_after_pop = count_q - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect_en) begin
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          state_d = ST_FETCH;
        end else if (count_after_pop < FULL) begin
          addr_d  = pc_q;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_ready) begin
          if (redirect_en) begin
            // Returned word belongs to the old stream: drop it and
            // immediately request the new target.
            pc_d   = redirect_pc;
            addr_d = redirect_pc;
          end else begin
            push   = 1'b1;
            pc_d   = pc_q + 16'd1;
            addr_d = pc_q + 16'd1;
            if (count_after_pop + 2'd1 == FULL) begin
              state_d = ST_IDLE;
            end
          end
        end else if (redirect_en) begin
          // The request cannot be withdrawn; keep it stable and swallow
          // its data in DISCARD.
          pc_d    = redirect_pc;
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (redirect_en) begin
          pc_d = redirect_pc;
        end
        if (mem_ready) begin
          addr_d  = pc_d;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Two-entry shift queue: entry 0 is always the head.
  always_comb begin
    count_d    = count_q;
    e0_instr_d = e0_instr_q;
    e0_pc_d    = e0_pc_q;
    e1_instr_d = e1_instr_q;
    e1_pc_d    = e1_pc_q;
    if (redirect_en) begin
      count_d = 2'd0;
    end else begin
      count_d = count_after_pop + {1'b0, push};
      if (pop) begin
        e0_instr_d = e1_instr_q;
        e0_pc_d    = e1_pc_q;
      end
      if (push) begin
        if (count_after_pop == 2'd0) begin
          e0_instr_d = mem_data;
          e0_pc_d    = addr_q;
        end else begin
          e1_instr_d = mem_data;
          e1_pc_d    = addr_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= 2'd0;
      e0_instr_q <= 16'h0000;
      e0_pc_q    <= 16'h0000;
      e1_instr_q <= 16'h0000;
      e1_pc_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      e0_instr_q <= e0_instr_d;
      e0_pc_q    <= e0_pc_d;
      e1_instr_q <= e1_instr_d;
      e1_pc_q    <= e1_pc_d;
    end
  end

  // A push into a full queue would silently lose an instruction.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == FULL)));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Reads 16-bit instruction words from word-addressed program memory through a req/ready port that tolerates wait states.
- Prefetches into a 2-entry queue and presents {instruction, pc} to the control unit over a valid/ready handshake.
- Flushes and restarts at a new PC when a branch or jump redirect arrives from writeback.

Parameters:
- RESET_PC, 16'h0100: PC loaded on reset (boot address 256).
- QUEUE_DEPTH, 2: prefetch entries. Fixed at 2; other values are unsupported.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- mem_req  out  1  memory read request.
- mem_addr  out  16  word address of the current request.
- mem_ready  in  1  memory accepts request; mem_data is valid this cycle.
- mem_data  in  16  read data, sampled only when mem_req && mem_ready.
- instr_valid  out  1  queue head is valid.
- instr_out  out  16  queue head instruction word.
- instr_pc  out  16  address the queue head was fetched from.
- instr_ready  in  1  control unit consumes the head this cycle.
- redirect_en  in  1  one-cycle pulse: flush and fetch from redirect_pc.
- redirect_pc  in  16  new fetch address.
- fetch_pc  out  16  next address to be requested (debug/trace).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; pc=fetch_pc=RESET_PC; mem_addr=RESET_PC; mem_req=0.
  - Queue count=0; instr_valid=0; instr_out=0; instr_pc=0.
  - Reset asserted mid-request abandons the request; memory must tolerate this.
- mem_req and instr_valid decode from registered state/count, so both are glitch-free and never combinationally dependent on inputs.
- Memory rule: once mem_req rises, mem_req and mem_addr stay stable until the cycle mem_ready=1. Requests are never aborted except by reset.
- FSM states: IDLE, FETCH, DISCARD.
  - IDLE:
    - mem_req=0.
    - If redirect_en: flush queue, pc<=redirect_pc, go FETCH.
    - Else if count_next<2: go FETCH.
    - mem_addr<=pc whenever entering FETCH.
  - FETCH:
    - mem_req=1, mem_addr=pc.
    - mem_ready=1 and no redirect: push {mem_data, pc}, then pc<=pc+1. Go IDLE if count_next==2, else stay FETCH with mem_addr<=pc+1.
    - mem_ready=1 with redirect_en: drop data, flush, pc<=redirect_pc, stay FETCH with mem_addr<=redirect_pc.
    - mem_ready=0 with redirect_en: flush, pc<=redirect_pc, go DISCARD. mem_addr holds the old address.
  - DISCARD:
    - mem_req=1 on the stale address.
    - On mem_ready: drop data, mem_addr<=pc, go FETCH.
    - redirect_en while in DISCARD: pc<=redirect_pc, stay DISCARD.
- Queue:
  - count in 0..2; instr_valid = (count!=0).
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle keep count unchanged.
  - The queue never pushes at count 2; a push at count 2 is a design error and must be asserted in simulation.
  - count_next = count + push − pop.
- Redirect has priority over pop and push in the same cycle: the queue is empty next cycle and instr_valid=0.
- Latency:
  - Zero wait states: address issued at edge N, entry valid after edge N+1.
  - Steady-state throughput is 1 word/cycle while instr_ready=1.
- PC arithmetic is 16-bit unsigned: 16'hFFFF+1 wraps to 16'h0000 with no flag.
- instr_out and instr_pc hold stable while instr_valid && !instr_ready.

Test Plan:
1. Reset, then release; memory has zero wait states with mem[0x100..0x103]=A,B,C,D; instr_ready=1 → first mem_req one edge after release at mem_addr=0x0100; instr_valid rises the next edge; sequence {A,0x100},{B,0x101},{C,0x102} one per cycle.
2. instr_ready=0 after reset → exactly two fetches (0x100, 0x101); mem_req drops with count=2; head stays {A,0x100}. Raise instr_ready for one cycle → one refetch at 0x102.
3. Memory with 3 wait states; redirect_en with redirect_pc=0x0200 one cycle after a request to 0x0105 issues → mem_addr stays 0x0105 until mem_ready; that data never appears at instr_out; next request is 0x0200; first delivered entry is {mem[0x200],0x0200}.
4. redirect_en in the same cycle as mem_ready and a pop at count=2 → queue empty next cycle; returned word dropped; mem_addr=redirect_pc.
5. redirect_pc=0xFFFE, zero wait states → fetched pcs 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order.
6. Assert rst low mid-wait-state with count=1 → instr_valid=0, mem_req=0, fetch_pc=0x0100 immediately (asynchronous); normal restart at 0x0100 after release.
